// File: rtl/obstacle_field_if.sv
// rtl/obstacle_field_if.sv - player/obstacle-stage signal bundle
//
// Purpose: groups the player-side inputs and the obstacle-stage outputs so
// both ends share one definition of the bus widths.
// Signals:
//   startRandom        player is in play position; request to run
//   game[1:0]          mode; bit0 selects ceiling (1) or ground (0) spawns
//   BallX/BallY/BallS  player centre X, centre Y and half-size
//   obs_valid          per-slot live flag
//   obs_x              per-slot left edge, slot i at [10i+9:10i]
//   obs_ceil           per-slot ceiling-obstacle flag
//   collided           sticky collision flag back to the player block
//   score              cleared-obstacle count for the HUD (saturating)
//   run_active         obstacle stage is in its RUN state
// Modports: master = player side, slave = obstacle stage.
interface obstacle_field_if #(
  parameter int NUM_OBS = 4
);
  logic                   startRandom;
  logic [1:0]             game;
  logic [9:0]             BallX;
  logic [9:0]             BallY;
  logic [9:0]             BallS;
  logic [NUM_OBS-1:0]     obs_valid;
  logic [10*NUM_OBS-1:0]  obs_x;
  logic [NUM_OBS-1:0]     obs_ceil;
  logic                   collided;
  logic [15:0]            score;
  logic                   run_active;

  modport master (
    output startRandom, game, BallX, BallY, BallS,
    input  obs_valid, obs_x, obs_ceil, collided, score, run_active
  );

  modport slave (
    input  startRandom, game, BallX, BallY, BallS,
    output obs_valid, obs_x, obs_ceil, collided, score, run_active
  );
endinterface

// File: rtl/obstacle_field.sv
// rtl/obstacle_field.sv - obstacle spawn, scroll, collision and score stage
//
// Purpose: once the player block raises startRandom, spawns pseudo-random
// obstacles at the right edge, scrolls them left once per frame, clears and
// counts those that leave the screen, and latches a collision against the
// player box (which freezes the field until Reset).
// Ports:
//   frame_clk  frame-rate clock, all state changes on its rising edge
//   Reset      synchronous, active-high reset
//   bus        obstacle_field_if.slave (player inputs, obstacle outputs)
module obstacle_field #(
  parameter int NUM_OBS     = 4,
  parameter int SCROLL_STEP = 4,
  parameter int OBS_W       = 16,
  parameter int OBS_H       = 24,
  parameter int SPAWN_X     = 624,
  parameter int GAP_MIN     = 40,
  parameter int FLOOR       = 429,
  parameter int CEILING     = 50
) (
  input  logic               frame_clk,
  input  logic               Reset,
  obstacle_field_if.slave    bus
);

  // Gap counter must hold GAP_MIN + 63.
  localparam int GAP_W = $clog2(GAP_MIN + 64);
  localparam int CNT_W = $clog2(NUM_OBS + 1);
  localparam int IDX_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

  state_t              state;
  logic [NUM_OBS-1:0]  obs_valid;
  logic [NUM_OBS-1:0]  obs_ceil;
  logic [9:0]          obs_x [NUM_OBS];
  logic                collided;
  logic                run_active;
  logic [15:0]         score;
  logic [15:0]         lfsr;
  logic [GAP_W-1:0]    gap_cnt;

  // Player box in 11 bits so the upper bounds cannot wrap.
  logic [10:0]         bx, by, bs;
  logic [10:0]         px_lo, px_hi, py_lo, py_hi;
  logic [NUM_OBS-1:0]  overlap;
  logic [NUM_OBS-1:0]  clr_mask;
  logic                hit_any;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic [CNT_W-1:0]    clr_cnt;
  logic [16:0]         score_sum;
  logic                lfsr_fb;
  logic [10*NUM_OBS-1:0] obs_x_flat;
  logic                unused_game_hi;

  assign unused_game_hi = bus.game[1];

  assign bx = {1'b0, bus.BallX};
  assign by = {1'b0, bus.BallY};
  assign bs = {1'b0, bus.BallS};

  // Lower bounds clamp at zero rather than wrapping.
  assign px_lo = (bx >= bs) ? (bx - bs) : 11'd0;
  assign px_hi = bx + bs;
  assign py_lo = (by >= bs) ? (by - bs) : 11'd0;
  assign py_hi = by + bs;

  for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_slot
    logic [10:0] ox_lo, ox_hi, oy_lo, oy_hi;
    assign ox_lo = {1'b0, obs_x[gi]};
    assign ox_hi = ox_lo + 11'(OBS_W - 1);
    assign oy_lo = obs_ceil[gi] ? 11'(CEILING) : 11'(FLOOR - OBS_H + 1);
    assign oy_hi = obs_ceil[gi] ? 11'(CEILING + OBS_H - 1) : 11'(FLOOR);
    assign overlap[gi] = obs_valid[gi]
                         && (px_lo <= ox_hi) && (ox_lo <= px_hi)
                         && (py_lo <= oy_hi) && (oy_lo <= py_hi);
    // A live slot that cannot take another full step leaves the screen.
    assign clr_mask[gi] = obs_valid[gi] && (obs_x[gi] < 10'(SCROLL_STEP));
  end

  assign hit_any   = |overlap;
  assign clr_cnt   = CNT_W'($countones(clr_mask));
  assign score_sum = {1'b0, score} + 17'(clr_cnt);

  // Taps 16,14,13,11 (bits 15,13,12,10), shifting toward the MSB.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Lowest-index slot free at the start of the edge; a slot clearing on
  // this edge is still counted as occupied.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (!obs_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= IDLE;
      obs_valid  <= '0;
      obs_ceil   <= '0;
      for (int i = 0; i < NUM_OBS; i++) begin
        obs_x[i] <= '0;
      end
      collided   <= 1'b0;
      run_active <= 1'b0;
      score      <= '0;
      gap_cnt    <= '0;
      lfsr       <= 16'hACE1;
    end else begin
      // Free-running in every state so the spawn pattern depends on idle time.
      lfsr <= {lfsr[14:0], lfsr_fb};
      case (state)
        IDLE: begin
          if (bus.startRandom) begin
            state      <= RUN;
            run_active <= 1'b1;
          end
        end
        RUN: begin
          if (hit_any) begin
            // Collision edge: nothing else moves.
            collided   <= 1'b1;
            run_active <= 1'b0;
            state      <= HIT;
          end else begin
            for (int i = 0; i < NUM_OBS; i++) begin
              if (obs_valid[i]) begin
                if (obs_x[i] >= 10'(SCROLL_STEP)) begin
                  obs_x[i] <= obs_x[i] - 10'(SCROLL_STEP);
                end else begin
                  obs_valid[i] <= 1'b0;
                end
              end
            end
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (gap_cnt == '0) begin
              // With no free slot the counter stays at zero and retries.
              if (free_found) begin
                obs_valid[free_idx] <= 1'b1;
                obs_x[free_idx]     <= 10'(SPAWN_X);
                obs_ceil[free_idx]  <= bus.game[0];
                gap_cnt             <= GAP_W'(GAP_MIN) + GAP_W'(lfsr[5:0]);
              end
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
        end
        HIT: begin
          // Frozen until Reset.
        end
        default: begin
          state      <= IDLE;
          run_active <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    obs_x_flat = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      obs_x_flat[10*i +: 10] = obs_x[i];
    end
  end

  assign bus.obs_valid  = obs_valid;
  assign bus.obs_x      = obs_x_flat;
  assign bus.obs_ceil   = obs_ceil;
  assign bus.collided   = collided;
  assign bus.score      = score;
  assign bus.run_active = run_active;

endmodule

// File: tb/tb_obstacle_field.sv
// tb/tb_obstacle_field.sv - self-checking bench for obstacle_field
module tb_obstacle_field;

  localparam int NOBS = 4;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  always #5 frame_clk = ~frame_clk;

  obstacle_field_if #(.NUM_OBS(NOBS)) bus_a ();
  obstacle_field_if #(.NUM_OBS(NOBS)) bus_b ();

  obstacle_field dut_a (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus_a.slave)
  );

  obstacle_field #(.GAP_MIN(1), .SCROLL_STEP(1)) dut_b (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus_b.slave)
  );

  int checks = 0;
  int errors = 0;

  // Shared stimulus for both instances.
  int in_sr, in_game, in_bx, in_by, in_bs;

  // Reference model, one copy per instance: 0 = default, 1 = GAP_MIN 1 / step 1.
  int gmin [2] = '{40, 1};
  int step [2] = '{4, 1};
  int mv [2][NOBS];
  int mx [2][NOBS];
  int mc [2][NOBS];
  int msc [2];
  int mcol [2];
  int mst [2];   // 0 idle, 1 running, 2 crashed
  int mgap [2];
  int mlfsr [2];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_in();
    bus_a.startRandom = in_sr[0];  bus_b.startRandom = in_sr[0];
    bus_a.game  = 2'(in_game);     bus_b.game  = 2'(in_game);
    bus_a.BallX = 10'(in_bx);      bus_b.BallX = 10'(in_bx);
    bus_a.BallY = 10'(in_by);      bus_b.BallY = 10'(in_by);
    bus_a.BallS = 10'(in_bs);      bus_b.BallS = 10'(in_bs);
  endtask

  task automatic set_ball(input int x, input int y, input int s);
    in_bx = x; in_by = y; in_bs = s;
    apply_in();
  endtask

  function automatic bit touches(input int m, input int i);
    int plx, phx, ply, phy, oyl, oyh;
    plx = in_bx - in_bs; if (plx < 0) plx = 0;
    ply = in_by - in_bs; if (ply < 0) ply = 0;
    phx = in_bx + in_bs;
    phy = in_by + in_bs;
    oyl = (mc[m][i] != 0) ? 50 : 429 - 24 + 1;
    oyh = oyl + 24 - 1;
    return (plx <= mx[m][i] + 15) && (mx[m][i] <= phx) && (ply <= oyh) && (oyl <= phy);
  endfunction

  task automatic model_edge(input int m);
    int hit, free, clr, ol;
    ol = mlfsr[m];
    if (Reset) begin
      for (int i = 0; i < NOBS; i++) begin
        mv[m][i] = 0; mx[m][i] = 0; mc[m][i] = 0;
      end
      msc[m] = 0; mcol[m] = 0; mst[m] = 0; mgap[m] = 0; mlfsr[m] = 'hACE1;
    end else begin
      mlfsr[m] = ((ol << 1) | int'(^(ol & 'hB400))) & 'hFFFF;
      if (mst[m] == 0) begin
        if (in_sr != 0) mst[m] = 1;
      end else if (mst[m] == 1) begin
        hit = 0;
        for (int i = 0; i < NOBS; i++)
          if (mv[m][i] != 0 && touches(m, i)) hit = 1;
        if (hit != 0) begin
          mcol[m] = 1;
          mst[m]  = 2;
        end else begin
          free = -1;
          for (int i = 0; i < NOBS; i++)
            if (mv[m][i] == 0 && free < 0) free = i;
          clr = 0;
          for (int i = 0; i < NOBS; i++) begin
            if (mv[m][i] != 0) begin
              if (mx[m][i] >= step[m]) mx[m][i] -= step[m];
              else begin mv[m][i] = 0; clr++; end
            end
          end
          msc[m] = (msc[m] + clr > 65535) ? 65535 : msc[m] + clr;
          if (mgap[m] == 0) begin
            if (free >= 0) begin
              mv[m][free] = 1;
              mx[m][free] = 624;
              mc[m][free] = in_game % 2;
              mgap[m] = gmin[m] + (ol % 64);
            end
          end else begin
            mgap[m]--;
          end
        end
      end
    end
  endtask

  task automatic check_model(input int m);
    logic [3:0]  v, c, ev, ec;
    logic [39:0] x, ex;
    logic        col, run;
    logic [15:0] sc;
    if (m == 0) begin
      v = bus_a.obs_valid; c = bus_a.obs_ceil; x = bus_a.obs_x;
      col = bus_a.collided; run = bus_a.run_active; sc = bus_a.score;
    end else begin
      v = bus_b.obs_valid; c = bus_b.obs_ceil; x = bus_b.obs_x;
      col = bus_b.collided; run = bus_b.run_active; sc = bus_b.score;
    end
    for (int i = 0; i < NOBS; i++) begin
      ev[i] = (mv[m][i] != 0);
      ec[i] = (mc[m][i] != 0);
      ex[10*i +: 10] = 10'(mx[m][i]);
    end
    chk($sformatf("model%0d valid", m), v, ev);
    chk($sformatf("model%0d x", m), x, ex);
    chk($sformatf("model%0d ceil", m), c, ec);
    chk($sformatf("model%0d collided", m), col, mcol[m]);
    chk($sformatf("model%0d run_active", m), run, (mst[m] == 1));
    chk($sformatf("model%0d score", m), sc, msc[m]);
  endtask

  task automatic tick();
    @(posedge frame_clk);
    model_edge(0);
    model_edge(1);
    @(negedge frame_clk);
    check_model(0);
    check_model(1);
  endtask

  typedef struct {
    bit       rst;
    bit       sr;
    bit [1:0] game;
    bit [3:0] ev;
    int       ex0;
    bit [3:0] eceil;
    bit       erun;
    bit       ecol;
    int       escore;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int k, since;

    in_sr = 0; in_game = 0; in_bx = 100; in_by = 240; in_bs = 8;
    apply_in();

    // Reset then a long idle stretch.
    Reset = 1'b1; tick();
    Reset = 1'b0;
    for (int n = 0; n < 100; n++) tick();
    chk("idle valid", bus_a.obs_valid, 0);
    chk("idle score", bus_a.score, 0);
    chk("idle run_active", bus_a.run_active, 0);
    chk("idle collided", bus_a.collided, 0);

    // Start sequence, spawn and first scroll edges.
    tbl[0] = '{1'b1, 1'b0, 2'd0, 4'h0, 0,   4'h0, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b0, 2'd0, 4'h0, 0,   4'h0, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b0, 1'b0, 2'd0, 4'h0, 0,   4'h0, 1'b0, 1'b0, 0};
    tbl[3] = '{1'b0, 1'b1, 2'd0, 4'h0, 0,   4'h0, 1'b1, 1'b0, 0};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 4'h1, 624, 4'h0, 1'b1, 1'b0, 0};
    tbl[5] = '{1'b0, 1'b1, 2'd0, 4'h1, 620, 4'h0, 1'b1, 1'b0, 0};
    tbl[6] = '{1'b0, 1'b0, 2'd0, 4'h1, 616, 4'h0, 1'b1, 1'b0, 0};
    tbl[7] = '{1'b0, 1'b0, 2'd1, 4'h1, 612, 4'h0, 1'b1, 1'b0, 0};
    tbl[8] = '{1'b0, 1'b0, 2'd0, 4'h1, 608, 4'h0, 1'b1, 1'b0, 0};
    for (int r = 0; r < 9; r++) begin
      Reset = tbl[r].rst; in_sr = int'(tbl[r].sr); in_game = int'(tbl[r].game);
      apply_in();
      tick();
      chk($sformatf("tbl%0d valid", r), bus_a.obs_valid, tbl[r].ev);
      chk($sformatf("tbl%0d x0", r), bus_a.obs_x[9:0], tbl[r].ex0);
      chk($sformatf("tbl%0d ceil", r), bus_a.obs_ceil, tbl[r].eceil);
      chk($sformatf("tbl%0d run", r), bus_a.run_active, tbl[r].erun);
      chk($sformatf("tbl%0d collided", r), bus_a.collided, tbl[r].ecol);
      chk($sformatf("tbl%0d score", r), bus_a.score, tbl[r].escore);
    end

    // Second spawn lands in slot1; gap loaded to 40..103 so it shows 41..104 edges later.
    since = 4; k = 0;
    while (!bus_a.obs_valid[1] && k < 150) begin tick(); since++; k++; end
    chk("second spawn seen", bus_a.obs_valid[1], 1);
    chk("second spawn gap in range", (since >= 41 && since <= 104), 1);
    chk("second spawn x", bus_a.obs_x[19:10], 624);
    chk("second spawn ground", bus_a.obs_ceil[1], 0);

    // Slot0 reaches x=0 after 156 scroll edges, clears on the next.
    k = 0;
    while (bus_a.obs_x[9:0] != 10'd0 && k < 200) begin tick(); since++; k++; end
    chk("slot0 scroll edges to zero", since, 156);
    tick();
    chk("slot0 cleared", bus_a.obs_valid[0], 0);
    chk("score after clear", bus_a.score, 1);

    // Ground collision at x=320.
    in_game = 0; set_ball(100, 240, 8);
    Reset = 1'b1; tick(); Reset = 1'b0;
    in_sr = 1; apply_in(); tick(); in_sr = 0; apply_in();
    k = 0;
    while (bus_a.obs_x[9:0] != 10'd320 && k < 120) begin tick(); k++; end
    chk("reached x320", bus_a.obs_x[9:0], 320);
    chk("no collision before", bus_a.collided, 0);
    set_ball(320, 429, 8);
    tick();
    chk("ground collided", bus_a.collided, 1);
    chk("hit frozen x", bus_a.obs_x[9:0], 320);
    chk("hit run_active", bus_a.run_active, 0);
    for (int n = 0; n < 50; n++) begin
      in_sr = n % 2; apply_in();
      tick();
      chk("hit hold x", bus_a.obs_x[9:0], 320);
      chk("hit hold collided", bus_a.collided, 1);
    end

    // Ceiling obstacles: Y-separated pass, then collide at the same X.
    in_sr = 0; in_game = 1; set_ball(100, 240, 8);
    Reset = 1'b1; tick(); Reset = 1'b0;
    in_sr = 1; apply_in(); tick(); in_sr = 0; apply_in(); tick();
    chk("ceil spawn valid", bus_a.obs_valid[0], 1);
    chk("ceil spawn flag", bus_a.obs_ceil[0], 1);
    k = 0;
    while (bus_a.obs_x[9:0] != 10'd100 && k < 200) begin tick(); k++; end
    chk("ceil reached x100", bus_a.obs_x[9:0], 100);
    chk("ceil low ball no hit", bus_a.collided, 0);
    set_ball(100, 58, 8);
    tick();
    chk("ceil collided", bus_a.collided, 1);

    // All slots full (GAP_MIN=1, step 1): hold, then reuse slot0.
    in_game = 0; set_ball(1000, 240, 8);
    Reset = 1'b1; tick(); Reset = 1'b0;
    in_sr = 1; apply_in(); tick(); in_sr = 0; apply_in();
    k = 0;
    while (bus_b.obs_valid != 4'hF && k < 400) begin tick(); k++; end
    chk("fill all slots", bus_b.obs_valid, 4'hF);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("full hold", bus_b.obs_valid, 4'hF);
    end
    k = 0;
    while (bus_b.obs_valid[0] && k < 800) begin tick(); k++; end
    chk("slot0 freed", bus_b.obs_valid, 4'hE);
    chk("full score", bus_b.score, 1);
    tick();
    chk("slot0 reused", bus_b.obs_valid, 4'hF);
    chk("slot0 respawn x", bus_b.obs_x[9:0], 624);

    // Mid-run reset.
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk("rst a valid", bus_a.obs_valid, 0);
    chk("rst a x", bus_a.obs_x, 0);
    chk("rst a score", bus_a.score, 0);
    chk("rst a run", bus_a.run_active, 0);
    chk("rst b valid", bus_b.obs_valid, 0);
    chk("rst b x", bus_b.obs_x, 0);
    chk("rst b ceil", bus_b.obs_ceil, 0);
    chk("rst b collided", bus_b.collided, 0);
    chk("rst b score", bus_b.score, 0);

    // Randomised run against the model.
    for (int n = 0; n < 3000; n++) begin
      Reset = ($urandom_range(0, 199) == 0);
      in_sr = ($urandom_range(0, 3) == 0) ? 1 : 0;
      in_game = int'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        in_bx = int'($urandom_range(0, 1023));
        in_by = int'($urandom_range(0, 1023));
        in_bs = int'($urandom_range(0, 300));
      end else begin
        in_bx = int'($urandom_range(0, 1023));
        in_by = int'($urandom_range(120, 360));
        in_bs = int'($urandom_range(0, 24));
      end
      apply_in();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
